decode_pipe: RTL and testbench

Registered, parametrised instruction decode stage for the PIC16-class core. Accepts one instruction word per cycle from the fetch register and produces registered ALU control fields for the execute stage. Covers the full byte/bit/literal/control instruction set, including skip and branch handling, with squash of the instruction following a taken skip or a branch.

---
 rtl/decode_pipe.sv | 192 +++++++++++++++++++
 tb/tb_decode_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// PIC16-class instruction decode stage: one word per cycle in, registered ALU
// control fields out, with squash of the word after a taken skip or a branch.
module decode_pipe #(
   parameter int F_W  = 7,
   parameter int K_W  = 8,
   parameter int A_W  = 11,
   parameter int OP_W = 4,
   localparam int INST_W = F_W + 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INST_W-1:0] inst_in,
   input  logic              inst_valid,
   input  logic              stall,
   input  logic              skip_taken,
   output logic [OP_W-1:0]   inst,
   output logic              d,
   output logic              switch_a_m,
   output logic [2:0]        bit_number,
   output logic [F_W-1:0]    f_addr,
   output logic [K_W-1:0]    literal,
   output logic [A_W-1:0]    target,
   output logic              dec_valid,
   output logic              is_skip,
   output logic              skip_on_set,
   output logic              is_call,
   output logic              is_goto,
   output logic              is_retlw,
   output logic              illegal
);

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic            d;
      logic            sam;
      logic [2:0]      bitn;
      logic [F_W-1:0]  fa;
      logic [K_W-1:0]  lit;
      logic [A_W-1:0]  tgt;
      logic            skip;
      logic            sos;
      logic            call;
      logic            jump;
      logic            retlw;
      logic            ill;
      logic            valid;
   } dec_t;

   function automatic logic [OP_W-1:0] opc(input logic [3:0] v);
      return OP_W'(v);
   endfunction

   // Bubble: NOP with every flag clear, also the reset image.
   function automatic dec_t bubble();
      dec_t b;
      b    = '0;
      b.op = opc(4'd1);
      return b;
   endfunction

   state_t state_r, state_s;
   dec_t   dec_s, nxt_s, out_r;

   logic [1:0] cls_s;
   logic [3:0] op4_s;
   logic [1:0] bop_s;

   assign cls_s = inst_in[INST_W-1 -: 2];
   assign op4_s = inst_in[INST_W-3 -: 4];
   assign bop_s = inst_in[F_W+4 -: 2];

   // Combinational decode of the presented word.
   always_comb begin
      dec_s       = bubble();
      dec_s.valid = 1'b1;
      case (cls_s)
         2'b00: begin
            dec_s.d   = inst_in[F_W];
            dec_s.sam = 1'b1;
            dec_s.fa  = inst_in[F_W-1:0];
            case (op4_s)
               4'h0:    dec_s.op = opc(4'd1);
               4'h1:    dec_s.op = opc(4'd9);
               4'h2:    dec_s.op = opc(4'd3);
               4'h3:    dec_s.op = opc(4'd6);
               4'h4:    dec_s.op = opc(4'd10);
               4'h5:    dec_s.op = opc(4'd4);
               4'h6:    dec_s.op = opc(4'd7);
               4'h7:    dec_s.op = opc(4'd2);
               4'h8:    dec_s.op = opc(4'd0);
               4'h9:    dec_s.op = opc(4'd12);
               4'hA:    dec_s.op = opc(4'd5);
               4'hB:    begin dec_s.op = opc(4'd6); dec_s.skip = 1'b1; end
               4'hC:    dec_s.op = opc(4'd15);
               4'hD:    dec_s.op = opc(4'd8);
               4'hE:    dec_s.op = opc(4'd11);
               4'hF:    begin dec_s.op = opc(4'd5); dec_s.skip = 1'b1; end
               default: begin dec_s.op = opc(4'd1); dec_s.ill = 1'b1; end
            endcase
         end
         2'b01: begin
            dec_s.bitn = inst_in[F_W+2 -: 3];
            dec_s.fa   = inst_in[F_W-1:0];
            dec_s.sam  = 1'b1;
            dec_s.d    = 1'b1;
            case (bop_s)
               2'b00:   dec_s.op = opc(4'd13);
               2'b01:   dec_s.op = opc(4'd14);
               2'b10:   begin dec_s.op = opc(4'd1); dec_s.skip = 1'b1; dec_s.d = 1'b0; end
               2'b11:   begin
                  dec_s.op   = opc(4'd1);
                  dec_s.skip = 1'b1;
                  dec_s.sos  = 1'b1;
                  dec_s.d    = 1'b0;
               end
               default: begin dec_s.op = opc(4'd1); dec_s.ill = 1'b1; end
            endcase
         end
         2'b11: begin
            dec_s.lit = inst_in[K_W-1:0];
            casez (op4_s)
               4'b00??: dec_s.op = opc(4'd0);
               4'b01??: begin dec_s.op = opc(4'd0); dec_s.retlw = 1'b1; end
               4'b1000: dec_s.op = opc(4'd10);
               4'b1001: dec_s.op = opc(4'd4);
               4'b1010: dec_s.op = opc(4'd7);
               4'b110?: dec_s.op = opc(4'd3);
               4'b111?: dec_s.op = opc(4'd2);
               default: begin dec_s.op = opc(4'd1); dec_s.ill = 1'b1; end
            endcase
         end
         2'b10: begin
            dec_s.tgt = inst_in[A_W-1:0];
            if (op4_s[3]) begin
               dec_s.jump = 1'b1;
            end else begin
               dec_s.call = 1'b1;
            end
         end
         default: dec_s.ill = 1'b1;
      endcase
   end

   // Next registered image and squash state; a squashed word never re-arms.
   always_comb begin
      nxt_s   = bubble();
      state_s = state_r;
      if (inst_valid) begin
         if (state_r == RUN) begin
            nxt_s = dec_s;
            if ((dec_s.skip && skip_taken) || dec_s.call || dec_s.jump || dec_s.retlw) begin
               state_s = SQUASH;
            end else begin
               state_s = RUN;
            end
         end else begin
            state_s = RUN;
         end
      end else begin
         state_s = state_r;
      end
   end

   // Output and state registers; stall freezes everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r   <= bubble();
         state_r <= RUN;
      end else if (!stall) begin
         out_r   <= nxt_s;
         state_r <= state_s;
      end
   end

   assign inst        = out_r.op;
   assign d           = out_r.d;
   assign switch_a_m  = out_r.sam;
   assign bit_number  = out_r.bitn;
   assign f_addr      = out_r.fa;
   assign literal     = out_r.lit;
   assign target      = out_r.tgt;
   assign dec_valid   = out_r.valid;
   assign is_skip     = out_r.skip;
   assign skip_on_set = out_r.sos;
   assign is_call     = out_r.call;
   assign is_goto     = out_r.jump;
   assign is_retlw    = out_r.retlw;
   assign illegal     = out_r.ill;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe at default widths.
module tb_decode_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] inst_in;
   logic        inst_valid;
   logic        stall;
   logic        skip_taken;
   logic [3:0]  inst;
   logic        d, switch_a_m, dec_valid, is_skip, skip_on_set;
   logic        is_call, is_goto, is_retlw, illegal;
   logic [2:0]  bit_number;
   logic [6:0]  f_addr;
   logic [7:0]  literal;
   logic [10:0] target;

   int total = 0;
   int bad   = 0;

   decode_pipe dut (
      .clk(clk), .reset(reset), .inst_in(inst_in), .inst_valid(inst_valid),
      .stall(stall), .skip_taken(skip_taken), .inst(inst), .d(d),
      .switch_a_m(switch_a_m), .bit_number(bit_number), .f_addr(f_addr),
      .literal(literal), .target(target), .dec_valid(dec_valid),
      .is_skip(is_skip), .skip_on_set(skip_on_set), .is_call(is_call),
      .is_goto(is_goto), .is_retlw(is_retlw), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [13:0] w, input logic v, input logic sk);
      inst_in    = w;
      inst_valid = v;
      skip_taken = sk;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; skip_taken = 1'b0;
      inst_in = 14'h0703; inst_valid = 1'b1;
      cyc(); cyc();
      total++; if (inst !== 4'd1) begin bad++; $display("FAIL rst_inst got=%0d exp=1", inst); end
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", dec_valid); end
      total++; if ({d, switch_a_m, bit_number, f_addr, literal, target} !== 32'd0) begin
         bad++; $display("FAIL rst_fields got=%h exp=0", {d, switch_a_m, bit_number, f_addr, literal, target}); end
      total++; if ({is_skip, skip_on_set, is_call, is_goto, is_retlw, illegal} !== 6'd0) begin
         bad++; $display("FAIL rst_flags got=%b exp=000000", {is_skip, skip_on_set, is_call, is_goto, is_retlw, illegal}); end
      reset = 1'b0;
      present(14'h0783, 1'b1, 1'b0);
      total++; if ({inst, d, f_addr, switch_a_m, dec_valid} !== {4'd2, 1'b1, 7'h03, 1'b1, 1'b1}) begin
         bad++; $display("FAIL addwf got inst=%0d d=%b f=%h sam=%b v=%b exp inst=2 d=1 f=03 sam=1 v=1",
                         inst, d, f_addr, switch_a_m, dec_valid); end
   endtask

   task automatic test_skip_taken();
      present(14'h0B85, 1'b1, 1'b1);
      total++; if ({inst, is_skip, d, f_addr, dec_valid} !== {4'd6, 1'b1, 1'b1, 7'h05, 1'b1}) begin
         bad++; $display("FAIL decfsz got inst=%0d skip=%b d=%b f=%h v=%b exp 6 1 1 05 1",
                         inst, is_skip, d, f_addr, dec_valid); end
      present(14'h3E10, 1'b1, 1'b0);
      total++; if ({dec_valid, inst, literal} !== {1'b0, 4'd1, 8'h00}) begin
         bad++; $display("FAIL skip_squash got v=%b inst=%0d lit=%h exp 0 1 00", dec_valid, inst, literal); end
      present(14'h0783, 1'b1, 1'b0);
      total++; if ({dec_valid, inst} !== {1'b1, 4'd2}) begin
         bad++; $display("FAIL after_squash got v=%b inst=%0d exp 1 2", dec_valid, inst); end
   endtask

   task automatic test_skip_not_taken();
      present(14'h0B85, 1'b1, 1'b0);
      present(14'h3E10, 1'b1, 1'b0);
      total++; if ({dec_valid, inst, literal, switch_a_m, d} !== {1'b1, 4'd2, 8'h10, 1'b0, 1'b0}) begin
         bad++; $display("FAIL addlw got v=%b inst=%0d lit=%h sam=%b d=%b exp 1 2 10 0 0",
                         dec_valid, inst, literal, switch_a_m, d); end
   endtask

   task automatic test_branch();
      present(14'h2A40, 1'b1, 1'b0);
      total++; if ({is_goto, is_call, target, inst, dec_valid, d} !== {1'b1, 1'b0, 11'h240, 4'd1, 1'b1, 1'b0}) begin
         bad++; $display("FAIL goto got goto=%b call=%b tgt=%h inst=%0d v=%b d=%b exp 1 0 240 1 1 0",
                         is_goto, is_call, target, inst, dec_valid, d); end
      present(14'h0000, 1'b0, 1'b0);
      total++; if ({dec_valid, is_goto} !== 2'b00) begin
         bad++; $display("FAIL bubble got v=%b goto=%b exp 0 0", dec_valid, is_goto); end
      present(14'h3005, 1'b1, 1'b0);
      total++; if ({dec_valid, inst, literal} !== {1'b0, 4'd1, 8'h00}) begin
         bad++; $display("FAIL goto_squash got v=%b inst=%0d lit=%h exp 0 1 00", dec_valid, inst, literal); end
      present(14'h3005, 1'b1, 1'b0);
      total++; if ({dec_valid, inst, literal} !== {1'b1, 4'd0, 8'h05}) begin
         bad++; $display("FAIL movlw got v=%b inst=%0d lit=%h exp 1 0 05", dec_valid, inst, literal); end
      // CALL squashes, and the squashed RETLW does not re-arm another squash.
      present(14'h2005, 1'b1, 1'b0);
      total++; if ({is_call, is_goto, target} !== {1'b1, 1'b0, 11'h005}) begin
         bad++; $display("FAIL call got call=%b goto=%b tgt=%h exp 1 0 005", is_call, is_goto, target); end
      present(14'h3412, 1'b1, 1'b0);
      total++; if ({dec_valid, is_retlw} !== 2'b00) begin
         bad++; $display("FAIL call_squash got v=%b retlw=%b exp 0 0", dec_valid, is_retlw); end
      present(14'h3412, 1'b1, 1'b0);
      total++; if ({dec_valid, is_retlw, inst, literal} !== {1'b1, 1'b1, 4'd0, 8'h12}) begin
         bad++; $display("FAIL retlw got v=%b retlw=%b inst=%0d lit=%h exp 1 1 0 12", dec_valid, is_retlw, inst, literal); end
      present(14'h3E01, 1'b1, 1'b0);
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL retlw_squash got v=%b exp 0", dec_valid); end
   endtask

   task automatic test_stall_reset();
      present(14'h1D86, 1'b1, 1'b0);
      inst_in = 14'h0783; skip_taken = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++; if ({is_skip, skip_on_set, bit_number, d, f_addr, inst, dec_valid} !==
                      {1'b1, 1'b1, 3'd3, 1'b0, 7'h06, 4'd1, 1'b1}) begin
            bad++; $display("FAIL stall_hold%0d got skip=%b sos=%b bit=%0d d=%b f=%h inst=%0d v=%b exp 1 1 3 0 06 1 1",
                            i, is_skip, skip_on_set, bit_number, d, f_addr, inst, dec_valid); end
      end
      #2 reset = 1'b1;
      #1;
      total++; if ({dec_valid, is_skip, skip_on_set} !== 3'b000) begin
         bad++; $display("FAIL async_rst got v=%b skip=%b sos=%b exp 000", dec_valid, is_skip, skip_on_set); end
      cyc();
      reset = 1'b0; stall = 1'b0; skip_taken = 1'b0;
      present(14'h0783, 1'b1, 1'b0);
      total++; if ({dec_valid, inst} !== {1'b1, 4'd2}) begin
         bad++; $display("FAIL post_rst got v=%b inst=%0d exp 1 2", dec_valid, inst); end
   endtask

   task automatic test_sweep();
      logic [3:0] byte_exp [16];
      logic [3:0] bit_exp  [4];
      logic [3:0] lit_op   [7];
      logic [3:0] lit_exp  [7];
      logic       lit_ill  [7];
      byte_exp = '{4'd1, 4'd9, 4'd3, 4'd6, 4'd10, 4'd4, 4'd7, 4'd2,
                   4'd0, 4'd12, 4'd5, 4'd6, 4'd15, 4'd8, 4'd11, 4'd5};
      bit_exp  = '{4'd13, 4'd14, 4'd1, 4'd1};
      lit_op   = '{4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
      lit_exp  = '{4'd0, 4'd10, 4'd4, 4'd7, 4'd1, 4'd3, 4'd2};
      lit_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 16; i++) begin
         present({2'b00, 4'(i), 1'b0, 7'h11}, 1'b1, 1'b0);
         total++; if ({inst, is_skip, illegal, dec_valid, d} !==
                      {byte_exp[i], (i == 11 || i == 15), 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL byte_op%0d got inst=%0d skip=%b ill=%b v=%b d=%b exp inst=%0d",
                            i, inst, is_skip, illegal, dec_valid, d, byte_exp[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         present({2'b01, 2'(i), 3'd5, 7'h22}, 1'b1, 1'b0);
         total++; if ({inst, bit_number, is_skip, skip_on_set, d, illegal} !==
                      {bit_exp[i], 3'd5, (i >= 2), (i == 3), (i < 2), 1'b0}) begin
            bad++; $display("FAIL bit_op%0d got inst=%0d bit=%0d skip=%b sos=%b d=%b ill=%b exp inst=%0d",
                            i, inst, bit_number, is_skip, skip_on_set, d, illegal, bit_exp[i]); end
      end
      for (int i = 0; i < 7; i++) begin
         present({2'b11, lit_op[i], 8'hA5}, 1'b1, 1'b0);
         total++; if ({inst, illegal, dec_valid, literal} !== {lit_exp[i], lit_ill[i], 1'b1, 8'hA5}) begin
            bad++; $display("FAIL lit_op%0d got inst=%0d ill=%b v=%b lit=%h exp inst=%0d ill=%b",
                            i, inst, illegal, dec_valid, literal, lit_exp[i], lit_ill[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_skip_taken();
      test_skip_not_taken();
      test_branch();
      test_stall_reset();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
